// File: rtl/stream_scaler.sv
// +--------------------------------------------------------------------------+
// | Module      : stream_scaler                                              |
// | Description : Avalon-ST multiply / round / shift / saturate pipeline     |
// |               with a CSR slave for coefficient, shift and statistics.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_scaler #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 3
) (
  input  logic              clk,
  input  logic              reset,
  // CSR slave
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  // Avalon-ST sink
  input  logic              asi_valid,
  input  logic [DATA_W-1:0] asi_data,
  output logic              asi_ready,
  // Avalon-ST source
  output logic              aso_valid,
  output logic [DATA_W-1:0] aso_data,
  input  logic              aso_ready
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW:0] RND_ONE = {{PW{1'b0}}, 1'b1};

  // CSR state
  logic [DATA_W-1:0] coeff_q;
  logic [5:0]        shift_q;
  logic [2:0]        ctrl_q;
  logic [31:0]       beat_cnt_q;
  logic [15:0]       sat_cnt_q;
  logic [31:0]       readdata_q;
  logic [31:0]       readdata_d;
  logic              csr_clr;
  logic              out_fire;

  // Pipeline state
  logic              stage_en [0:NUM_STAGES];
  logic              valid_q  [0:NUM_STAGES-1];
  logic [PW-1:0]     prod0_q;
  logic [5:0]        shift0_q;
  logic [2:0]        ctrl0_q;
  logic [PW:0]       res1_q;
  logic              sat_en1_q;
  logic              bypass1_q;
  logic [DATA_W-1:0] data_q   [2:NUM_STAGES-1];
  logic              sat_q    [2:NUM_STAGES-1];

  // Next-state values for the arithmetic stages
  logic [PW-1:0]     prod0_d;
  logic [PW:0]       round1_d;
  logic [PW:0]       res1_d;
  logic              ovf2_d;
  logic              sat2_d;
  logic [DATA_W-1:0] data2_d;

  // A stage may load when it is empty or when its content moves on this cycle
  assign stage_en[NUM_STAGES] = aso_ready;
  generate
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_enable
      assign stage_en[i] = !valid_q[i] || stage_en[i+1];
    end
  endgenerate

  assign asi_ready    = stage_en[0];
  assign aso_valid    = valid_q[NUM_STAGES-1];
  assign aso_data     = data_q[NUM_STAGES-1];
  assign avs_readdata = readdata_q;
  assign out_fire     = aso_valid && aso_ready;
  assign csr_clr      = avs_write && (avs_address == 3'd2) && avs_writedata[3];

  always_comb begin
    prod0_d  = '0;
    round1_d = '0;
    res1_d   = '0;
    if (ctrl_q[0]) begin
      prod0_d[DATA_W-1:0] = asi_data;
    end else begin
      prod0_d = {{DATA_W{1'b0}}, asi_data} * {{DATA_W{1'b0}}, coeff_q};
    end
    if (ctrl0_q[2] && (shift0_q != 6'd0)) begin
      round1_d = RND_ONE << (shift0_q - 6'd1);
    end
    if (ctrl0_q[0]) begin
      res1_d = {1'b0, prod0_q};
    end else begin
      res1_d = ({1'b0, prod0_q} + round1_d) >> shift0_q;
    end
    ovf2_d  = !bypass1_q && (|res1_q[PW:DATA_W]);
    sat2_d  = ovf2_d && sat_en1_q;
    data2_d = sat2_d ? {DATA_W{1'b1}} : res1_q[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        valid_q[i] <= 1'b0;
      end
      prod0_q   <= '0;
      shift0_q  <= '0;
      ctrl0_q   <= '0;
      res1_q    <= '0;
      sat_en1_q <= 1'b0;
      bypass1_q <= 1'b0;
      for (int i = 2; i < NUM_STAGES; i++) begin
        data_q[i] <= '0;
        sat_q[i]  <= 1'b0;
      end
    end else begin
      if (stage_en[0]) begin
        valid_q[0] <= asi_valid;
      end
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (stage_en[i]) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
      // CSR snapshot travels with the beat so later writes never touch it
      if (stage_en[0] && asi_valid) begin
        prod0_q  <= prod0_d;
        shift0_q <= shift_q;
        ctrl0_q  <= ctrl_q;
      end
      if (stage_en[1] && valid_q[0]) begin
        res1_q    <= res1_d;
        sat_en1_q <= ctrl0_q[1];
        bypass1_q <= ctrl0_q[0];
      end
      if (stage_en[2] && valid_q[1]) begin
        data_q[2] <= data2_d;
        sat_q[2]  <= sat2_d;
      end
      for (int i = 3; i < NUM_STAGES; i++) begin
        if (stage_en[i] && valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          sat_q[i]  <= sat_q[i-1];
        end
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    case (avs_address)
      3'd0:    readdata_d[DATA_W-1:0] = coeff_q;
      3'd1:    readdata_d[5:0]        = shift_q;
      3'd2:    readdata_d[2:0]        = ctrl_q;
      3'd3:    readdata_d             = beat_cnt_q;
      3'd4:    readdata_d[15:0]       = sat_cnt_q;
      default: readdata_d             = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coeff_q    <= {{(DATA_W-1){1'b0}}, 1'b1};
      shift_q    <= '0;
      ctrl_q     <= '0;
      beat_cnt_q <= '0;
      sat_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0:    coeff_q <= avs_writedata[DATA_W-1:0];
          3'd1:    shift_q <= avs_writedata[5:0];
          3'd2:    ctrl_q  <= avs_writedata[2:0];
          default: ;
        endcase
      end
      // Clear has priority over a coincident increment
      if (csr_clr) begin
        beat_cnt_q <= '0;
        sat_cnt_q  <= '0;
      end else begin
        if (out_fire) begin
          beat_cnt_q <= beat_cnt_q + 32'd1;
        end
        if (out_fire && sat_q[NUM_STAGES-1] && (sat_cnt_q != 16'hFFFF)) begin
          sat_cnt_q <= sat_cnt_q + 16'd1;
        end
      end
      if (avs_read) begin
        readdata_q <= readdata_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_scaler.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_stream_scaler                                           |
// | Description : Randomised self-checking bench with a reference model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_stream_scaler;

  localparam int DW = 32;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    avs_address;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic          avs_read;
  logic [31:0]   avs_readdata;
  logic          asi_valid;
  logic [DW-1:0] asi_data;
  logic          asi_ready;
  logic          aso_valid;
  logic [DW-1:0] aso_data;
  logic          aso_ready;

  stream_scaler #(.DATA_W(DW), .NUM_STAGES(NS)) dut (
    .clk          (clk),
    .reset        (reset),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .asi_valid    (asi_valid),
    .asi_data     (asi_data),
    .asi_ready    (asi_ready),
    .aso_valid    (aso_valid),
    .aso_data     (aso_data),
    .aso_ready    (aso_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the arithmetic the spec describes, done on wide integers
  function automatic void model_out(input logic [31:0] d, input logic [31:0] c,
                                    input logic [5:0] sh, input logic [2:0] ct,
                                    output logic [31:0] o, output bit s);
    logic [64:0] p, r, res;
    s = 1'b0;
    if (ct[0]) begin
      o = d;
      return;
    end
    p   = 65'(d) * 65'(c);
    r   = (ct[2] && sh != 6'd0) ? (65'd1 << (sh - 6'd1)) : 65'd0;
    res = (p + r) >> sh;
    o   = res[31:0];
    if (res > 65'h0_FFFF_FFFF && ct[1]) begin
      o = 32'hFFFF_FFFF;
      s = 1'b1;
    end
  endfunction

  typedef struct {
    logic [31:0] d;
    bit          s;
    int          c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_coeff;
  logic [5:0]  m_shift;
  logic [2:0]  m_ctrl;
  logic [31:0] m_beat;
  logic [15:0] m_sat;
  int          cyc = 0;
  int          n_out = 0;
  logic [31:0] last_out = '0;
  bit          lat_chk = 0;
  bit          hold = 0;
  logic [31:0] held;
  int          bp_mode = 0;
  logic        man_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output side driver: 0 always ready, 1 random, 2 stalled, 3 manual
  initial begin
    aso_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0: aso_ready = 1'b1;
        1: aso_ready = ($urandom_range(0, 3) != 0);
        2: aso_ready = 1'b0;
        default: aso_ready = man_ready;
      endcase
    end
  end

  // Monitor + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_coeff = 32'd1; m_shift = '0; m_ctrl = '0; m_beat = '0; m_sat = '0;
      hold = 0;
    end else begin
      if (hold) begin
        check_eq("hold_valid", aso_valid, 1);
        check_eq("hold_data", aso_data, held);
      end
      hold = aso_valid && !aso_ready;
      held = aso_data;
      if (aso_valid && aso_ready) begin
        m_beat++;
        if (q.size() == 0) begin
          check_eq("unexpected_out", aso_valid, 0);
        end else begin
          e = q.pop_front();
          check_eq("out_data", aso_data, e.d);
          if (lat_chk) check_eq("latency", cyc - e.c, NS);
          if (e.s && m_sat != 16'hFFFF) m_sat++;
          n_out++;
          last_out = aso_data;
        end
      end
      if (asi_valid && asi_ready) begin
        model_out(asi_data, m_coeff, m_shift, m_ctrl, e.d, e.s);
        e.c = cyc;
        q.push_back(e);
      end
      if (avs_write) begin
        case (avs_address)
          3'd0: m_coeff = avs_writedata;
          3'd1: m_shift = avs_writedata[5:0];
          3'd2: begin
            m_ctrl = avs_writedata[2:0];
            if (avs_writedata[3]) begin m_beat = '0; m_sat = '0; end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check_eq(tag, avs_readdata, exp);
  endtask

  task automatic send(input logic [31:0] d);
    int k = 0;
    asi_valid = 1'b1; asi_data = d;
    do begin
      @(negedge clk);
      k++;
    end while (!asi_ready && k < 200);
    if (!asi_ready) begin
      check_eq("send_timeout", asi_ready, 1);
      asi_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    asi_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bp_mode = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check_eq("drain", q.size(), 0);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
    avs_read = 1'b0; asi_valid = 1'b0; asi_data = '0;
    tick(2);
    @(negedge clk);
    check_eq("rst_asi_ready", asi_ready, 1);
    check_eq("rst_aso_valid", aso_valid, 0);
    check_eq("rst_aso_data", aso_data, 0);
    check_eq("rst_readdata", avs_readdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);

    read_chk("def_coeff", 3'd0, 1);
    read_chk("def_shift", 3'd1, 0);
    read_chk("def_ctrl", 3'd2, 0);
    read_chk("def_beat", 3'd3, 0);
    read_chk("def_sat", 3'd4, 0);
    csr_write(3'd5, 32'hDEAD_BEEF);
    read_chk("unmapped", 3'd5, 0);
    csr_write(3'd2, 32'hF);
    read_chk("ctrl_clr_reads0", 3'd2, 7);
    csr_write(3'd2, 32'h0);

    // Basic latency / throughput
    lat_chk = 1;
    send(5); send(6); send(7);
    drain();
    lat_chk = 0;
    read_chk("beat_cnt3", 3'd3, 3);

    // Rounded scaling
    csr_write(3'd0, 1311); csr_write(3'd1, 19); csr_write(3'd2, 4);
    send(400000); drain();
    check_eq("round_1000", last_out, 1000);
    send(0); drain();
    check_eq("round_zero", last_out, 0);

    // Saturation vs truncation
    csr_write(3'd0, 2); csr_write(3'd1, 0); csr_write(3'd2, 2);
    send(32'hFFFF_FFFF); drain();
    check_eq("sat_on", last_out, 32'hFFFF_FFFF);
    read_chk("sat_cnt1", 3'd4, 1);
    csr_write(3'd2, 0);
    send(32'hFFFF_FFFF); drain();
    check_eq("sat_off", last_out, 32'hFFFF_FFFE);
    read_chk("sat_cnt_hold", 3'd4, 1);

    // Backpressure: exactly NS beats absorbed, nothing lost
    csr_write(3'd0, 1);
    base = n_out;
    bp_mode = 2;
    tick(1);
    send(1); send(2); send(3);
    @(negedge clk);
    check_eq("absorb_full", asi_ready, 0);
    tick(0);
    fork
      begin
        for (int v = 4; v <= 10; v++) send(v);
      end
      begin
        tick(4);
        bp_mode = 0;
      end
    join
    drain();
    check_eq("stall_count", n_out - base, 10);

    // Coefficient change with beats in flight, then bypass
    send(11); send(12);
    csr_write(3'd0, 3);
    send(13); drain();
    check_eq("coeff_x3", last_out, 39);
    csr_write(3'd2, 1);
    send(32'h1234_5678); drain();
    check_eq("bypass", last_out, 32'h1234_5678);

    // Randomised traffic with random CSR updates and backpressure
    csr_write(3'd2, 0);
    bp_mode = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        int a;
        a = $urandom_range(0, 7);
        if (a == 2) csr_write(3'(a), $urandom & 32'hF);
        else if (a == 0) csr_write(3'(a), ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 300));
        else csr_write(3'(a), $urandom);
      end else if (r < 8) begin
        send(($urandom_range(0, 2) == 0) ? $urandom_range(0, 1000) : $urandom);
      end else begin
        tick(1);
      end
      if (n % 100 == 99) bp_mode = 1;
    end
    drain();
    read_chk("rand_beat", 3'd3, m_beat);
    read_chk("rand_sat", 3'd4, {16'h0, m_sat});

    // Reset with beats in flight
    csr_write(3'd0, 7); csr_write(3'd2, 0);
    bp_mode = 2;
    tick(1);
    send(100); send(101); send(102);
    tick(1);
    reset = 1'b1;
    tick(2);
    check_eq("midrst_ready", asi_ready, 1);
    reset = 1'b0;
    bp_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_valid", aso_valid, 0);
    end
    tick(1);
    read_chk("post_rst_beat", 3'd3, 0);
    read_chk("post_rst_sat", 3'd4, 0);
    read_chk("post_rst_coeff", 3'd0, 1);

    // Counter clear coinciding with an output handshake
    send(1); send(2); drain();
    read_chk("beat_before_clr", 3'd3, 2);
    man_ready = 1'b0;
    bp_mode = 3;
    tick(1);
    send(3);
    tick(3);
    man_ready = 1'b1;
    avs_address = 3'd2; avs_writedata = 32'h8; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    man_ready = 1'b0;
    tick(1);
    read_chk("clr_wins", 3'd3, 0);
    bp_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
